// File: rtl/posit_pkg.sv
// Shared posit constants and helpers: default word/exponent widths and a
// ceil(log2) function used to size the regime fields.
package posit_pkg;
  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/alignment_if.sv
// Operand/result bundle for the posit alignment stage. The master drives
// decoded operands, the slave (alignment) returns the aligned sum and scale.
interface alignment_if #(
  parameter int N  = posit_pkg::POSIT_N,
  parameter int ES = posit_pkg::POSIT_ES
);
  localparam int RS = posit_pkg::clog2_f(N);
  localparam int M  = N - ES + 3;
  localparam int LW = ES + RS + 1;

  logic signed [N-2:0]  InRemain1, InRemain2;
  logic                 Sign1, Sign2;
  logic signed [RS:0]   RegimeValue1, RegimeValue2;
  logic [ES-1:0]        Exponent1, Exponent2;
  logic [M-1:0]         Mantissa1, Mantissa2;
  logic [N-1:0]         E_diff;
  logic [N-1:0]         Add_Mant;
  logic signed [LW-1:0] LE_O;
  logic [ES-1:0]        E_O;
  logic signed [RS-1:0] R_O;

  modport master (
    output InRemain1, InRemain2, Sign1, Sign2, RegimeValue1, RegimeValue2,
           Exponent1, Exponent2, Mantissa1, Mantissa2,
    input  E_diff, Add_Mant, LE_O, E_O, R_O
  );
  modport slave (
    input  InRemain1, InRemain2, Sign1, Sign2, RegimeValue1, RegimeValue2,
           Exponent1, Exponent2, Mantissa1, Mantissa2,
    output E_diff, Add_Mant, LE_O, E_O, R_O
  );
endinterface

// File: rtl/alignment_shifter.sv
// Right barrel shifter for the small mantissa. Shift amounts of M or more
// flush to zero. Build option ALIGNMENT_STICKY_EN folds every shifted-out
// bit into the result LSB; without it those bits are simply dropped.
module alignment_shifter #(
  parameter int M  = 8,
  parameter int SW = 8
) (
  input  logic [M-1:0]  din_i,
  input  logic [SW-1:0] shamt_i,
  output logic [M-1:0]  dout_o
);
  // Logical shift with saturation to zero, optional sticky OR.
  always_comb begin
    dout_o = '0;
    if (int'(shamt_i) < M) dout_o = din_i >> shamt_i;
`ifdef ALIGNMENT_STICKY_EN
    dout_o[0] = dout_o[0] | (|(din_i & ~({M{1'b1}} << shamt_i)));
`else
    dout_o[0] = dout_o[0];
`endif
  end
endmodule

// File: rtl/alignment.sv
// Posit add/sub alignment stage: picks the larger-scale operand, aligns the
// smaller mantissa to it, adds or subtracts, and registers the magnitude and
// result scale. One-cycle latency, accepts operands every cycle.
// Build option: ALIGNMENT_STICKY_EN (sticky bit on the alignment shift).
module alignment #(
  parameter int N  = posit_pkg::POSIT_N,
  parameter int ES = posit_pkg::POSIT_ES
) (
  input logic       clk,
  input logic       reset,
  alignment_if.slave bus
);
  import posit_pkg::*;

  localparam int RS = clog2_f(N);
  localparam int M  = N - ES + 3;
  localparam int LW = ES + RS + 1;
  localparam int DW = LW + 1;   // scale difference can reach 2*max scale

  logic signed [LW-1:0] le1, le2, le_l, le_s, le_res;
  logic [M-1:0]         m_l, m_s, m_s_sh, res;
  logic [DW-1:0]        diff;
  logic [M:0]           sum;
  logic                 op1_large, same_sign, carry;

  logic [N-1:0]         e_diff_d, e_diff_q, add_d, add_q;
  logic signed [LW-1:0] le_d, le_q;
  logic [ES-1:0]        e_d, e_q;
  logic signed [RS-1:0] r_d, r_q;

  // Remainder fields ride along on the bus but the datapath ignores them.
  logic unused_remain;
  assign unused_remain = ^{bus.InRemain1, bus.InRemain2};

  // Operand scales, large/small selection and scale difference.
  always_comb begin
    le1 = (LW'(bus.RegimeValue1) <<< ES) + LW'(bus.Exponent1);
    le2 = (LW'(bus.RegimeValue2) <<< ES) + LW'(bus.Exponent2);
    op1_large = (le1 > le2) || ((le1 == le2) && (bus.Mantissa1 >= bus.Mantissa2));
    le_l = op1_large ? le1 : le2;
    le_s = op1_large ? le2 : le1;
    m_l  = op1_large ? bus.Mantissa1 : bus.Mantissa2;
    m_s  = op1_large ? bus.Mantissa2 : bus.Mantissa1;
    diff = DW'(le_l) - DW'(le_s);
  end

  alignment_shifter #(.M(M), .SW(DW)) u_shift (
    .din_i   (m_s),
    .shamt_i (diff),
    .dout_o  (m_s_sh)
  );

  // Add/subtract, carry renormalization and scale update.
  always_comb begin
    same_sign = (bus.Sign1 == bus.Sign2);
    if (same_sign) sum = {1'b0, m_l} + {1'b0, m_s_sh};
    else           sum = {1'b0, m_l} - {1'b0, m_s_sh};
    carry  = same_sign & sum[M];
    res    = carry ? sum[M:1] : sum[M-1:0];
    le_res = carry ? le_l + LW'(1) : le_l;
    e_diff_d = N'(diff);
    le_d     = le_res;
    e_d      = le_res[ES-1:0];
    r_d      = RS'(le_res >>> ES);
  end

  // Mantissa output takes the top N bits, padding LSBs if M is narrower.
  if (M >= N) begin : g_trunc
    assign add_d = res[M-1 -: N];
  end else begin : g_pad
    assign add_d = {res, {(N-M){1'b0}}};
  end

  // Output registers; reset overrides capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_diff_q <= '0;
      add_q    <= '0;
      le_q     <= '0;
      e_q      <= '0;
      r_q      <= '0;
    end else begin
      e_diff_q <= e_diff_d;
      add_q    <= add_d;
      le_q     <= le_d;
      e_q      <= e_d;
      r_q      <= r_d;
    end
  end

  assign bus.E_diff   = e_diff_q;
  assign bus.Add_Mant = add_q;
  assign bus.LE_O     = le_q;
  assign bus.E_O      = e_q;
  assign bus.R_O      = r_q;
endmodule

// File: tb/tb_alignment.sv
// Directed bench for the alignment stage (N=8, ES=3, default build).
// Expected results are queued when operands are driven and checked one
// edge later.
module tb_alignment;
  import posit_pkg::*;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = clog2_f(N);
  localparam int M  = N - ES + 3;
  localparam int LW = ES + RS + 1;

  typedef struct packed {
    logic [N-1:0]  ediff;
    logic [N-1:0]  add;
    logic [LW-1:0] le;
    logic [ES-1:0] e;
    logic [RS-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alignment_if #(.N(N), .ES(ES)) bus ();
  alignment #(.N(N), .ES(ES)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic exp_t mk(input int ediff, input int add, input int le,
                              input int e, input int r);
    exp_t x;
    x.ediff = N'(ediff);
    x.add   = N'(add);
    x.le    = LW'(le);
    x.e     = ES'(e);
    x.r     = RS'(r);
    return x;
  endfunction

  task automatic ops(input int r1, input int e1, input int m1, input int s1,
                     input int r2, input int e2, input int m2, input int s2);
    bus.RegimeValue1 = (RS+1)'(r1);
    bus.Exponent1    = ES'(e1);
    bus.Mantissa1    = M'(m1);
    bus.Sign1        = 1'(s1);
    bus.RegimeValue2 = (RS+1)'(r2);
    bus.Exponent2    = ES'(e2);
    bus.Mantissa2    = M'(m2);
    bus.Sign2        = 1'(s2);
    bus.InRemain1    = (N-1)'($urandom);
    bus.InRemain2    = (N-1)'($urandom);
  endtask

  task automatic step(input string tag, input exp_t x);
    exp_t got, want;
    sb.push_back(x);
    @(posedge clk);
    #1;
    want      = sb.pop_front();
    got.ediff = bus.E_diff;
    got.add   = bus.Add_Mant;
    got.le    = bus.LE_O;
    got.e     = bus.E_O;
    got.r     = bus.R_O;
    n_assert++;
    assert (got.ediff === want.ediff) else begin
      n_fail++; $error("FAIL %s E_diff: got %0h want %0h", tag, got.ediff, want.ediff);
    end
    n_assert++;
    assert (got.add === want.add) else begin
      n_fail++; $error("FAIL %s Add_Mant: got %0h want %0h", tag, got.add, want.add);
    end
    n_assert++;
    assert (got.le === want.le) else begin
      n_fail++; $error("FAIL %s LE_O: got %0h want %0h", tag, got.le, want.le);
    end
    n_assert++;
    assert (got.e === want.e) else begin
      n_fail++; $error("FAIL %s E_O: got %0h want %0h", tag, got.e, want.e);
    end
    n_assert++;
    assert (got.r === want.r) else begin
      n_fail++; $error("FAIL %s R_O: got %0h want %0h", tag, got.r, want.r);
    end
  endtask

  initial begin
    // Reset held with live operands: outputs must stay zero.
    reset = 1'b1;
    ops(2, 3, 'h80, 0, 1, 5, 'hC0, 0);
    step("rst_init", mk(0, 'h00, 0, 0, 0));
    reset = 1'b0;

    ops(0, 0, 'h00, 0, 0, 0, 'h00, 0);
    step("all_zero", mk(0, 'h00, 0, 0, 0));
    ops(2, 3, 'h80, 0, 1, 5, 'hC0, 0);
    step("add_d6", mk(6, 'h83, 19, 3, 2));
    ops(-1, 3, 'hC0, 0, -2, 5, 'hC0, 0);
    step("neg_scale", mk(6, 'hC3, -5, 3, -1));
    ops(0, 0, 'h80, 0, 0, 0, 'h80, 0);
    step("carry", mk(0, 'h80, 1, 1, 0));
    ops(0, 0, 'hC0, 0, 0, 0, 'h80, 1);
    step("sub_eq", mk(0, 'h40, 0, 0, 0));
    // Operand 2 has the larger scale.
    ops(1, 5, 'hC0, 0, 2, 3, 'h80, 0);
    step("swap", mk(6, 'h83, 19, 3, 2));
    // Shift beyond mantissa width flushes the small operand.
    ops(3, 0, 'h80, 0, 0, 0, 'hFF, 0);
    step("flush", mk(24, 'h80, 24, 0, 3));
    ops(0, 1, 'h80, 0, 0, 0, 'h80, 1);
    step("sub_d1", mk(1, 'h40, 1, 1, 0));
    // Equal scale, mantissa 2 larger: operand 2 wins.
    ops(0, 0, 'h80, 0, 0, 0, 'hC0, 1);
    step("sub_m2", mk(0, 'h40, 0, 0, 0));
    // Shifted-out bits are truncated in the default build.
    ops(0, 2, 'h80, 0, 0, 0, 'h83, 0);
    step("trunc", mk(2, 'hA0, 2, 2, 0));
    // Both negative with carry out of a negative scale.
    ops(-1, 7, 'hC0, 1, -1, 7, 'hC0, 1);
    step("neg_carry", mk(0, 'hC0, 0, 0, 0));
    ops(3, 7, 'h80, 0, -8, 0, 'hFF, 0);
    step("max_diff", mk(95, 'h80, 31, 7, 3));

    // Mid-stream reset overrides live operands.
    ops(2, 3, 'h80, 0, 1, 5, 'hC0, 0);
    reset = 1'b1;
    step("rst_mid", mk(0, 'h00, 0, 0, 0));
    reset = 1'b0;
    ops(-1, 3, 'hC0, 0, -2, 5, 'hC0, 0);
    step("recover", mk(6, 'hC3, -5, 3, -1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
